// File: rtl/acqbuf_ctrl_pkg.sv
// acqbuf_ctrl_pkg: shared state type and effective-length helper for the acquisition capture controller
package acqbuf_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // A zero or oversized length means a full-buffer record
  function automatic int eff_len(input int len, input int aw);
    return (len == 0 || len > (1 << aw)) ? (1 << aw) : len;
  endfunction

endpackage

// File: rtl/acq_decim.sv
// acq_decim: decimation counter that strobes take on 1 of every decim+1 valid samples
module acq_decim #(
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   s_valid,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic                   take
);

  logic [DECIM_WIDTH-1:0] dcnt;

  assign take = s_valid && dcnt == '0;

  // Reload on a take, count down on other valid samples, restart on clear
  always_ff @(posedge clk or posedge rst)
    if (rst) dcnt <= '0;
    else if (clr) dcnt <= '0;
    else if (take) dcnt <= decim;
    else if (s_valid) dcnt <= dcnt - 1'b1;

endmodule

// File: rtl/acqbuf_ctrl.sv
// acqbuf_ctrl: armed/triggered capture of a decimated sample record into one BRAM; ACQBUF_CTRL_PRETRIG_EN adds pre-trigger capture
module acqbuf_ctrl
  import acqbuf_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 64,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig,
  input  logic [DECIM_WIDTH-1:0] decim,
  input  logic [ADDR_WIDTH:0]    length,
  input  logic [ADDR_WIDTH-1:0]  pretrig,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   bram_we,
  output logic [ADDR_WIDTH-1:0]  bram_waddr,
  output logic [DATA_WIDTH-1:0]  bram_wdata,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  start_addr
);

  state_t                 state, state_n;
  logic [DECIM_WIDTH-1:0] decim_q;
  logic [ADDR_WIDTH:0]    l_eff, p_eff, last_q, post;
  logic [ADDR_WIDTH-1:0]  wptr;
  logic                   take, wr, acc, fill_ok, arm_ok, counted;

  assign l_eff   = (ADDR_WIDTH+1)'(eff_len(int'(length), ADDR_WIDTH));
  assign arm_ok  = arm && !abort && (state == IDLE || state == DONE);
  assign counted = state == CAPTURE || acc;
  assign busy    = state == ARMED || state == CAPTURE;
  assign done    = state == DONE;

  acq_decim #(.DECIM_WIDTH(DECIM_WIDTH)) u_decim (
    .clk(clk),
    .rst(rst),
    .clr(state_n != state),
    .s_valid(s_valid),
    .decim(decim_q),
    .take(take)
  );

`ifdef ACQBUF_CTRL_PRETRIG_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  logic [ADDR_WIDTH:0] pre_q, fill;
  assign p_eff   = ({1'b0, pretrig} < l_eff - 1'b1) ? {1'b0, pretrig} : l_eff - 1'b1;
  assign fill_ok = fill >= pre_q;
  // Pre-trigger fill level (saturating) and record start address captured on trigger
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre_q      <= '0;
      fill       <= '0;
      start_addr <= '0;
    end else if (arm_ok) begin
      pre_q      <= p_eff;
      fill       <= '0;
      start_addr <= '0;
    end else begin
      if (state == ARMED && wr && fill < DEPTH_W) fill <= fill + 1'b1;
      if (acc) start_addr <= wptr - pre_q[ADDR_WIDTH-1:0];
    end
`else
  logic unused_pretrig;
  assign unused_pretrig = ^pretrig;
  assign p_eff          = '0;
  assign fill_ok        = 1'b1;
  assign start_addr     = '0;
`endif

  // Next state, write strobe and trigger acceptance; abort overrides everything
  always_comb begin
    state_n = state;
    wr      = 1'b0;
    acc     = 1'b0;
    case (state)
      IDLE: state_n = arm ? ARMED : IDLE;
      ARMED: begin
        acc = trig && fill_ok;
`ifdef ACQBUF_CTRL_PRETRIG_EN
        wr  = take;
`else
        wr  = take && acc;
`endif
        if (acc) state_n = (take && last_q == '0) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        wr = take;
        if (take && post == last_q) state_n = DONE;
      end
      DONE: state_n = arm ? ARMED : DONE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      wr      = 1'b0;
      acc     = 1'b0;
    end
  end

  // State, record bookkeeping and the registered BRAM write port
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      decim_q    <= '0;
      last_q     <= '0;
      post       <= '0;
      wptr       <= '0;
      bram_we    <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
    end else begin
      state   <= state_n;
      bram_we <= wr;
      if (wr) begin
        bram_waddr <= wptr;
        bram_wdata <= s_data;
      end
      if (arm_ok) begin
        decim_q <= decim;
        last_q  <= l_eff - p_eff - 1'b1;
        wptr    <= '0;
        post    <= '0;
      end else if (wr) begin
        wptr <= wptr + 1'b1;
        if (counted) post <= post + 1'b1;
      end
    end

endmodule

// File: tb/tb_acqbuf_ctrl.sv
// tb_acqbuf_ctrl: directed self-checking bench for acqbuf_ctrl (ADDR_WIDTH=4); pre-trigger cases run when ACQBUF_CTRL_PRETRIG_EN is defined
module tb_acqbuf_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0, abort = 1'b0, trig = 1'b0, s_valid = 1'b0;
  logic [7:0]  decim = '0;
  logic [4:0]  length = '0;
  logic [3:0]  pretrig = '0;
  logic [63:0] s_data = '0;
  logic        bram_we, busy, done;
  logic [3:0]  bram_waddr, start_addr;
  logic [63:0] bram_wdata;
  int          pass_cnt = 0;
  int          total = 0;

  acqbuf_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .DECIM_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
    .decim(decim), .length(length), .pretrig(pretrig),
    .s_valid(s_valid), .s_data(s_data),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
    .busy(busy), .done(done), .start_addr(start_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [7:0] d, input logic [4:0] l, input logic [3:0] p);
    decim = d; length = l; pretrig = p; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    total++;
    if ({bram_we, bram_waddr, bram_wdata, busy, done, start_addr} !== '0)
      $display("FAIL reset: we=%b addr=%h data=%h busy=%b done=%b start=%h, want all 0", bram_we, bram_waddr, bram_wdata, busy, done, start_addr);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_length(input logic [4:0] l, input int n, input int base);
    do_arm(8'd0, l, 4'd0);
    total++;
    if ({busy, done, bram_we} !== 3'b100)
      $display("FAIL len%0d_armed: busy=%b done=%b we=%b, want 1 0 0", l, busy, done, bram_we);
    else pass_cnt++;
    s_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      s_data = 64'(base + i);
      trig = (i == 0);
      tick();
      total++;
      if ({bram_we, bram_waddr, bram_wdata, done, busy} !== {1'b1, 4'(i), 64'(base + i), i == n - 1, i != n - 1})
        $display("FAIL len%0d_write%0d: we=%b addr=%0d data=%0d done=%b busy=%b, want 1 %0d %0d %b %b", l, i, bram_we, bram_waddr, bram_wdata, done, busy, i, base + i, i == n - 1, i != n - 1);
      else pass_cnt++;
    end
    trig = 1'b0;
    tick();
    total++;
    if ({bram_we, done, busy, start_addr} !== {3'b010, 4'd0})
      $display("FAIL len%0d_after: we=%b done=%b busy=%b start=%0d, want 0 1 0 0", l, bram_we, done, busy, start_addr);
    else pass_cnt++;
    s_valid = 1'b0;
  endtask

  task automatic test_decim();
    int vcnt = 0, wcnt = 0, seen = 0;
    logic exp_we;
    do_arm(8'd3, 5'd4, 4'd0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int c = 0; c < 24; c++) begin
      s_valid = (c % 3 != 2);
      s_data = 64'(300 + c);
      exp_we = s_valid && (vcnt % 4 == 0) && wcnt < 4;
      tick();
      total++;
      if (bram_we !== exp_we || (exp_we && {bram_waddr, bram_wdata} !== {4'(wcnt), 64'(300 + c)}))
        $display("FAIL decim_cyc%0d: we=%b addr=%0d data=%0d, want we=%b addr=%0d data=%0d", c, bram_we, bram_waddr, bram_wdata, exp_we, wcnt, 300 + c);
      else pass_cnt++;
      if (bram_we) seen++;
      if (exp_we) wcnt++;
      if (s_valid) vcnt++;
    end
    s_valid = 1'b0;
    total++;
    if (seen !== 4 || done !== 1'b1)
      $display("FAIL decim_total: writes=%0d done=%b, want 4 1", seen, done);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    do_arm(8'd0, 5'd8, 4'd0);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 64'(700 + i);
      trig = (i == 0);
      tick();
      total++;
      if ({bram_we, bram_waddr} !== {1'b1, 4'(i)})
        $display("FAIL abort_write%0d: we=%b addr=%0d, want 1 %0d", i, bram_we, bram_waddr, i);
      else pass_cnt++;
    end
    trig = 1'b0; s_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({bram_we, busy, done} !== 3'b000)
      $display("FAIL abort_idle: we=%b busy=%b done=%b, want 0 0 0", bram_we, busy, done);
    else pass_cnt++;
    s_valid = 1'b1; trig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bram_we, busy} !== 2'b00)
        $display("FAIL abort_trig%0d: we=%b busy=%b, want 0 0", i, bram_we, busy);
      else pass_cnt++;
    end
    s_valid = 1'b0; trig = 1'b0;
  endtask

  task automatic test_arm_abort();
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    total++;
    if ({busy, done} !== 2'b00)
      $display("FAIL arm_abort: busy=%b done=%b, want 0 0", busy, done);
    else pass_cnt++;
    trig = 1'b1; s_valid = 1'b1;
    tick();
    trig = 1'b0; s_valid = 1'b0;
    total++;
    if ({bram_we, busy} !== 2'b00)
      $display("FAIL arm_abort_trig: we=%b busy=%b, want 0 0", bram_we, busy);
    else pass_cnt++;
  endtask

  task automatic test_arm_capture();
    do_arm(8'd0, 5'd4, 4'd0);
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 64'(800 + i);
      trig = (i == 0);
      arm = (i == 2);
      tick();
      total++;
      if ({bram_we, bram_waddr, bram_wdata, done} !== {1'b1, 4'(i), 64'(800 + i), i == 3})
        $display("FAIL arm_capture%0d: we=%b addr=%0d data=%0d done=%b, want 1 %0d %0d %b", i, bram_we, bram_waddr, bram_wdata, done, i, 800 + i, i == 3);
      else pass_cnt++;
    end
    trig = 1'b0; arm = 1'b0;
    tick();
    s_valid = 1'b0;
    total++;
    if ({bram_we, done} !== 2'b01)
      $display("FAIL arm_capture_end: we=%b done=%b, want 0 1", bram_we, done);
    else pass_cnt++;
  endtask

`ifdef ACQBUF_CTRL_PRETRIG_EN
  task automatic test_pretrig();
    do_arm(8'd0, 5'd8, 4'd3);
    s_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      s_data = 64'(500 + i);
      trig = (i == 1 || i == 10);
      tick();
      total++;
      if ({bram_we, bram_waddr, bram_wdata, done, busy} !== {1'b1, 4'(i), 64'(500 + i), i == 14, i != 14})
        $display("FAIL pretrig_write%0d: we=%b addr=%0d data=%0d done=%b busy=%b, want 1 %0d %0d %b %b", i, bram_we, bram_waddr, bram_wdata, done, busy, i, 500 + i, i == 14, i != 14);
      else pass_cnt++;
      if (i == 10) begin
        total++;
        if (start_addr !== 4'd7)
          $display("FAIL pretrig_start: start=%0d, want 7", start_addr);
        else pass_cnt++;
      end
    end
    trig = 1'b0;
    tick();
    s_valid = 1'b0;
    total++;
    if ({bram_we, done, start_addr} !== {2'b01, 4'd7})
      $display("FAIL pretrig_end: we=%b done=%b start=%0d, want 0 1 7", bram_we, done, start_addr);
    else pass_cnt++;
  endtask
`else
  task automatic test_no_pretrig();
    do_arm(8'd0, 5'd4, 4'd3);
    s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({bram_we, busy} !== 2'b01)
        $display("FAIL nopre_armed%0d: we=%b busy=%b, want 0 1", i, bram_we, busy);
      else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      s_data = 64'(900 + i);
      trig = (i == 0);
      tick();
      total++;
      if ({bram_we, bram_waddr, done, start_addr} !== {1'b1, 4'(i), i == 3, 4'd0})
        $display("FAIL nopre_write%0d: we=%b addr=%0d done=%b start=%0d, want 1 %0d %b 0", i, bram_we, bram_waddr, done, start_addr, i, i == 3);
      else pass_cnt++;
    end
    trig = 1'b0; s_valid = 1'b0;
  endtask
`endif

  task automatic test_rst_mid();
    do_arm(8'd0, 5'd8, 4'd3);
    s_valid = 1'b1;
    s_data = 64'hDEAD_BEEF;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bram_we, bram_waddr, bram_wdata, busy, done, start_addr} !== '0)
      $display("FAIL rst_mid: we=%b addr=%h data=%h busy=%b done=%b start=%h, want all 0", bram_we, bram_waddr, bram_wdata, busy, done, start_addr);
    else pass_cnt++;
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_length(5'd8, 8, 100);
    test_decim();
    test_length(5'd0, 16, 200);
    test_abort();
    test_arm_abort();
    test_arm_capture();
`ifdef ACQBUF_CTRL_PRETRIG_EN
    test_pretrig();
`else
    test_no_pretrig();
`endif
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/acqbuf_ctrl.md
# acqbuf_ctrl

Capture controller for the ADC acquisition buffers. It sits between an ADC AXI4-stream sample path and the write port of one acquisition BRAM, which the host reads through the lb3 BRAM bus. Host config registers arm it and a DSP trigger pulse starts it; it then writes a decimated, length-limited sample record into the BRAM. One instance per acquisition buffer.

## Interface
Parameters:
- ADDR_WIDTH, 12, BRAM address width; depth = 2^ADDR_WIDTH words
- DATA_WIDTH, 64, sample word width; matches the ADC AXIS data width
- DECIM_WIDTH, 8, width of the decimation ratio

Ports:
- clk  in  1  capture clock (ADC stream clock); the only clock
- rst  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle pulse that starts a capture sequence
- abort  in  1  single-cycle pulse that returns to IDLE
- trig  in  1  trigger pulse
- decim  in  DECIM_WIDTH  keep 1 of every decim+1 valid samples; latched on arm
- length  in  ADDR_WIDTH+1  record length in words; 0 or >depth means depth; latched on arm
- pretrig  in  ADDR_WIDTH  pre-trigger words; latched on arm; ignored without the macro
- s_valid  in  1  ADC sample valid; there is no backpressure
- s_data  in  DATA_WIDTH  ADC sample
- bram_we  out  1  BRAM write enable
- bram_waddr  out  ADDR_WIDTH  BRAM write address
- bram_wdata  out  DATA_WIDTH  BRAM write data
- busy  out  1  high in ARMED and CAPTURE
- done  out  1  record complete; held until the next arm, abort or rst
- start_addr  out  ADDR_WIDTH  address of the first record word

## Operation
- States are IDLE, ARMED, CAPTURE and DONE.
- Take strobe: a sample is taken when s_valid && dcnt==0.
  - On a take, dcnt reloads to decim.
  - On s_valid without a take, dcnt decrements.
  - dcnt clears on every state entry.
- IDLE or DONE + arm → ARMED:
  - latch decim, length and pretrig;
  - clear done, wptr and counters.
- arm in ARMED or CAPTURE is ignored. trig in IDLE or DONE is ignored.
- ARMED without pretrigger: no writes. trig → CAPTURE.
- CAPTURE:
  - each take writes s_data at wptr, then wptr++ modulo depth and post++;
  - after the write with post == L−1 (L = effective length), go to DONE.
- abort in any state → IDLE next cycle. done clears. A write already issued completes.
- arm and abort in the same cycle: abort wins.
- trig coincident with a take in ARMED: that sample is the first post-trigger word.
- Width rules:
  - post and L are ADDR_WIDTH+1 bits;
  - address arithmetic wraps modulo 2^ADDR_WIDTH.

## Timing
- The write port is registered: bram_we/waddr/wdata assert 1 cycle after the take cycle.
- The first CAPTURE write can come from the trig cycle's own take.
- done and busy update in the same cycle as the last bram_we.
- Reset values:
  - state IDLE;
  - all outputs 0, including bram_wdata and start_addr.
- Mid-capture rst clears everything asynchronously. BRAM contents are undefined afterwards.

## Configuration
Macro: ACQBUF_CTRL_PRETRIG_EN. It controls pre-trigger capture.

With the macro defined:
- Effective pretrigger P = min(pretrig, L−1).
- ARMED writes every take circularly at wptr and counts fill, saturating at depth.
- trig is ignored until fill ≥ P (holdoff).
- On an accepted trig, go to CAPTURE with post = 0. CAPTURE writes L−P words.
- start_addr = (trig address − P) mod depth, registered on trig.

Without the macro:
- pretrig is ignored and start_addr stays 0.
- No pre-trigger logic is built.
- The port list is identical in both cases.

## Structure
- Package acqbuf_ctrl_pkg holds:
  - the typedef enum logic [1:0] state type: IDLE=0, ARMED=1, CAPTURE=2, DONE=3;
  - a function for the effective length.
- Sub-module acq_decim holds the dcnt counter, the reload logic and the take output. It clears on a clear input.

## Test plan
- decim=0, length=8, arm, then trig with continuous s_valid → 8 writes at addresses 0..7 on consecutive cycles; done 1 cycle after the trig cycle's take + 7; start_addr 0.
- decim=3, length=4 → writes on every 4th valid sample; s_valid gaps stall the counter; exactly 4 writes, then done.
- length=0 with ADDR_WIDTH=4 → 16 writes, last address 15, no wrap write.
- abort during CAPTURE after 3 writes → IDLE next cycle; done=0, busy=0; a later trig produces no writes.
- arm+abort in the same cycle → stays IDLE. arm during CAPTURE → ignored; the record still completes.
- PRETRIG_EN, ADDR_WIDTH=4, length=8, pretrig=3:
  - trig before 3 takes → ignored;
  - trig after 10 takes (write address 10) → 5 post-trigger writes at 10..14 and start_addr = 7;
  - rst asserted mid-ARMED → all outputs 0 immediately.
